// File: rtl/sha_msg_schedule_pkg.sv
// Shared constants, state type and configuration check
// for the SHA-2 message schedule generator.
package sha_msg_schedule_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // SHA-256 sigma amounts
   localparam int S256_S0_R1 = 7;
   localparam int S256_S0_R2 = 18;
   localparam int S256_S0_SH = 3;
   localparam int S256_S1_R1 = 17;
   localparam int S256_S1_R2 = 19;
   localparam int S256_S1_SH = 10;

   // SHA-512 sigma amounts
   localparam int S512_S0_R1 = 1;
   localparam int S512_S0_R2 = 8;
   localparam int S512_S0_SH = 7;
   localparam int S512_S1_R1 = 19;
   localparam int S512_S1_R2 = 61;
   localparam int S512_S1_SH = 6;

   // k: 0 = first rotate, 1 = second rotate, 2 = shift
   function automatic int sig_amt(
      input int ww,
      input bit sel,
      input int k
   );
      int r;
      r = 0;
      if (ww == 64) begin
         if (!sel) r = (k == 0) ? S512_S0_R1 :
                       (k == 1) ? S512_S0_R2 : S512_S0_SH;
         else      r = (k == 0) ? S512_S1_R1 :
                       (k == 1) ? S512_S1_R2 : S512_S1_SH;
      end else begin
         if (!sel) r = (k == 0) ? S256_S0_R1 :
                       (k == 1) ? S256_S0_R2 : S256_S0_SH;
         else      r = (k == 0) ? S256_S1_R1 :
                       (k == 1) ? S256_S1_R2 : S256_S1_SH;
      end
      return r;
   endfunction

   function automatic bit cfg_ok(
      input int ww,
      input int rounds
   );
      return ((ww == 32) || (ww == 64)) && (rounds >= 16);
   endfunction

endpackage

// File: rtl/sha_sched_sigma.sv
// Small sigma function of the SHA-2 schedule; SEL=0 gives s0,
// SEL=1 gives s1.
module sha_sched_sigma
   import sha_msg_schedule_pkg::*;
#(
   parameter int WORD_WIDTH = 32,
   parameter bit SEL        = 1'b0
) (
   input  logic [WORD_WIDTH-1:0] x,
   output logic [WORD_WIDTH-1:0] y
);

   localparam int R1 = sig_amt(WORD_WIDTH, SEL, 0);
   localparam int R2 = sig_amt(WORD_WIDTH, SEL, 1);
   localparam int SH = sig_amt(WORD_WIDTH, SEL, 2);

   logic [WORD_WIDTH-1:0] rot1;
   logic [WORD_WIDTH-1:0] rot2;

   always_comb begin
      rot1 = (x >> R1) | (x << (WORD_WIDTH - R1));
      rot2 = (x >> R2) | (x << (WORD_WIDTH - R2));
      y    = rot1 ^ rot2 ^ (x >> SH);
   end

endmodule

// File: rtl/sha_msg_schedule.sv
// Streaming SHA-2 message schedule: loads a 16-word block and
// emits W[0..ROUNDS-1] from a 16-word sliding window.
module sha_msg_schedule
   import sha_msg_schedule_pkg::*;
#(
   parameter  int WORD_WIDTH  = 32,
   parameter  int ROUNDS      = 64,
   localparam int BLOCK_WIDTH = 16 * WORD_WIDTH,
   localparam int IW          = $clog2(ROUNDS)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   block_valid,
   output logic                   block_ready,
   input  logic [BLOCK_WIDTH-1:0] block_data,
   output logic                   w_valid,
   input  logic                   w_ready,
   output logic [WORD_WIDTH-1:0]  w_data,
   output logic [IW-1:0]          w_index,
   output logic                   w_last,
   output logic                   busy
);

   if (!cfg_ok(WORD_WIDTH, ROUNDS)) begin : g_bad_cfg
      $error("sha_msg_schedule: illegal WORD_WIDTH/ROUNDS");
   end

   localparam logic [IW-1:0] LAST_IDX = IW'(ROUNDS - 1);

   state_e                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [WORD_WIDTH-1:0] window_q [16];
   logic [WORD_WIDTH-1:0] window_d [16];

   logic [WORD_WIDTH-1:0] sig0;
   logic [WORD_WIDTH-1:0] sig1;
   logic [WORD_WIDTH-1:0] w_next;
   logic                  run;
   logic                  load;
   logic                  fire;

   sha_sched_sigma #(
      .WORD_WIDTH (WORD_WIDTH),
      .SEL        (1'b0)
   ) u_sig0 (
      .x (window_q[1]),
      .y (sig0)
   );

   sha_sched_sigma #(
      .WORD_WIDTH (WORD_WIDTH),
      .SEL        (1'b1)
   ) u_sig1 (
      .x (window_q[14]),
      .y (sig1)
   );

   assign w_next = sig1 + window_q[9] + sig0 + window_q[0];

   assign run     = (state_q == RUN);
   assign w_valid = run;
   assign busy    = run;
   assign w_index = idx_q;
   assign w_last  = run && (idx_q == LAST_IDX);
   assign w_data  = run ? window_q[0] : '0;

   // ready combinationally follows w_ready on the last word so
   // consecutive blocks stream without a bubble
   assign block_ready = !clear && (!run || (w_last && w_ready));
   assign load        = block_valid && block_ready;
   assign fire        = w_valid && w_ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      for (int i = 0; i < 16; i++) begin
         window_d[i] = window_q[i];
      end
      if (clear) begin
         state_d = IDLE;
         idx_d   = '0;
      end else if (load) begin
         state_d = RUN;
         idx_d   = '0;
         for (int i = 0; i < 16; i++) begin
            window_d[i] =
               block_data[BLOCK_WIDTH-1-i*WORD_WIDTH -: WORD_WIDTH];
         end
      end else if (fire) begin
         if (w_last) begin
            state_d = IDLE;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + IW'(1);
            for (int i = 0; i < 15; i++) begin
               window_d[i] = window_q[i+1];
            end
            window_d[15] = w_next;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         for (int i = 0; i < 16; i++) begin
            window_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         for (int i = 0; i < 16; i++) begin
            window_q[i] <= window_d[i];
         end
      end
   end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Randomised bench for sha_msg_schedule: SHA-256 and SHA-512
// instances checked against a full-array schedule model.
module tb_sha_msg_schedule;

   logic clock;
   logic reset;

   logic         clr32, bv32, br32, wv32, wr32, wl32, bs32;
   logic [511:0] bd32;
   logic [31:0]  wd32;
   logic [5:0]   wi32;

   logic          clr64, bv64, br64, wv64, wr64, wl64, bs64;
   logic [1023:0] bd64;
   logic [63:0]   wd64;
   logic [6:0]    wi64;

   int n_checks;
   int n_errors;

   logic [63:0] wexp [80];

   sha_msg_schedule #(.WORD_WIDTH(32), .ROUNDS(64)) dut32 (
      .clock       (clock),
      .reset       (reset),
      .clear       (clr32),
      .block_valid (bv32),
      .block_ready (br32),
      .block_data  (bd32),
      .w_valid     (wv32),
      .w_ready     (wr32),
      .w_data      (wd32),
      .w_index     (wi32),
      .w_last      (wl32),
      .busy        (bs32)
   );

   sha_msg_schedule #(.WORD_WIDTH(64), .ROUNDS(80)) dut64 (
      .clock       (clock),
      .reset       (reset),
      .clear       (clr64),
      .block_valid (bv64),
      .block_ready (br64),
      .block_data  (bd64),
      .w_valid     (wv64),
      .w_ready     (wr64),
      .w_data      (wd64),
      .w_index     (wi64),
      .w_last      (wl64),
      .busy        (bs64)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model: plain SHA-2 schedule over a full W array
   function automatic logic [63:0] rotr(input logic [63:0] x,
                                         input int n, input int ww);
      logic [31:0] h;
      if (ww == 32) begin
         h = x[31:0];
         return {32'b0, (h >> n) | (h << (32 - n))};
      end
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [63:0] ms0(input logic [63:0] x,
                                        input int ww);
      if (ww == 32)
         return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
      return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
   endfunction

   function automatic logic [63:0] ms1(input logic [63:0] x,
                                        input int ww);
      if (ww == 32)
         return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
      return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
   endfunction

   task automatic build_model(input logic [1023:0] blk,
                              input int ww, input int rounds);
      logic [63:0] mask;
      mask = (ww == 32) ? 64'hFFFF_FFFF : '1;
      for (int i = 0; i < 16; i++)
         wexp[i] = 64'(blk >> ((15 - i) * ww)) & mask;
      for (int t = 16; t < rounds; t++)
         wexp[t] = (ms1(wexp[t-2], ww) + wexp[t-7] +
                    ms0(wexp[t-15], ww) + wexp[t-16]) & mask;
   endtask

   function automatic logic [1023:0] rand_block();
      logic [1023:0] b;
      for (int i = 0; i < 32; i++) b[i*32 +: 32] = $urandom();
      return b;
   endfunction

   // per-instance accessors, d=0 -> SHA-256, d=1 -> SHA-512
   function automatic logic [63:0] o_data(input int d);
      return d ? wd64 : {32'b0, wd32};
   endfunction
   function automatic int o_idx(input int d);
      return d ? int'(wi64) : int'(wi32);
   endfunction
   function automatic logic o_valid(input int d);
      return d ? wv64 : wv32;
   endfunction
   function automatic logic o_last(input int d);
      return d ? wl64 : wl32;
   endfunction
   function automatic logic o_busy(input int d);
      return d ? bs64 : bs32;
   endfunction
   function automatic logic o_bready(input int d);
      return d ? br64 : br32;
   endfunction

   task automatic drive(input int d, input logic bv,
                        input logic [1023:0] blk,
                        input logic wr, input logic clr);
      if (d != 0) begin
         bv64 = bv; bd64 = blk; wr64 = wr; clr64 = clr;
      end else begin
         bv32 = bv; bd32 = blk[511:0]; wr32 = wr; clr32 = clr;
      end
   endtask

   task automatic check_reset_vals(input int d, input string tag);
      check({tag, "_w_valid"}, 64'(o_valid(d)), 64'd0);
      check({tag, "_w_last"},  64'(o_last(d)),  64'd0);
      check({tag, "_busy"},    64'(o_busy(d)),  64'd0);
      check({tag, "_w_data"},  o_data(d),       64'd0);
      check({tag, "_w_index"}, 64'(o_idx(d)),   64'd0);
      check({tag, "_bready"},  64'(o_bready(d)), 64'd1);
   endtask

   task automatic check_idle(input int d, input string tag);
      check({tag, "_w_valid"}, 64'(o_valid(d)),  64'd0);
      check({tag, "_busy"},    64'(o_busy(d)),   64'd0);
      check({tag, "_bready"},  64'(o_bready(d)), 64'd1);
   endtask

   task automatic load(input int d, input logic [1023:0] blk);
      @(negedge clock);
      drive(d, 1'b1, blk, 1'b0, 1'b0);
      #1;
      check("load_bready", 64'(o_bready(d)), 64'd1);
   endtask

   // consume one block; on the last word optionally present nxt
   task automatic stream(input int d, input int rounds,
                         input int pct, input bit kat,
                         input bit b2b,
                         input logic [1023:0] nxt);
      int t, cyc;
      logic wr, stalled;
      logic [63:0] pdata;
      int pidx;
      t = 0; cyc = 0; stalled = 1'b0; pdata = '0; pidx = 0;
      while (t < rounds && cyc < 4000) begin
         @(negedge clock);
         cyc++;
         wr = ($urandom_range(0, 99) < pct);
         if (b2b && t == rounds - 1) drive(d, 1'b1, nxt, 1'b1, 1'b0);
         else drive(d, 1'b0, nxt, wr, 1'b0);
         if (b2b && t == rounds - 1) wr = 1'b1;
         #1;
         check("w_valid", 64'(o_valid(d)), 64'd1);
         check("w_index", 64'(o_idx(d)), 64'(t));
         check("w_data",  o_data(d), wexp[t]);
         check("w_last",  64'(o_last(d)), 64'(t == rounds - 1));
         if (stalled) begin
            check("stall_data", o_data(d), pdata);
            check("stall_idx",  64'(o_idx(d)), 64'(pidx));
         end
         if (kat) begin
            if (d == 0) begin
               if (t == 0)  check("kat256_w0",  o_data(d), 64'h61626380);
               if (t == 15) check("kat256_w15", o_data(d), 64'h00000018);
               if (t == 16) check("kat256_w16", o_data(d), 64'h61626380);
               if (t == 17) check("kat256_w17", o_data(d), 64'h000F0000);
            end else begin
               if (t == 0)  check("kat512_w0",  o_data(d), 64'h6162638000000000);
               if (t == 15) check("kat512_w15", o_data(d), 64'h18);
               if (t == 16) check("kat512_w16", o_data(d), 64'h6162638000000000);
               if (t == 17) check("kat512_w17", o_data(d), 64'h00030000000000C0);
            end
         end
         if (b2b && t == rounds - 1)
            check("b2b_bready", 64'(o_bready(d)), 64'd1);
         stalled = !wr;
         pdata = o_data(d);
         pidx = o_idx(d);
         if (wr) t++;
      end
      if (t < rounds) check("stream_timeout", 64'(t), 64'(rounds));
   endtask

   task automatic run_to_index(input int d, input int target);
      int cyc;
      cyc = 0;
      forever begin
         @(negedge clock);
         drive(d, 1'b0, '0, 1'b1, 1'b0);
         #1;
         if (o_idx(d) == target && o_valid(d)) break;
         cyc++;
         if (cyc > 200) begin
            check("run_to_index_timeout", 64'(o_idx(d)), 64'(target));
            break;
         end
      end
   endtask

   logic [1023:0] abc256, abc512, blk_a, blk_b;

   initial begin
      n_checks = 0;
      n_errors = 0;
      abc256 = '0;
      abc256[511:0] = {32'h61626380, 448'b0, 32'h00000018};
      abc512 = {64'h6162638000000000, 896'b0, 64'h18};
      reset = 1'b1;
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      drive(1, 1'b0, '0, 1'b0, 1'b0);
      #12;
      check_reset_vals(0, "rst256");
      check_reset_vals(1, "rst512");
      @(negedge clock);
      reset = 1'b0;

      // SHA-256 abc, full throughput
      build_model(abc256, 32, 64);
      load(0, abc256);
      stream(0, 64, 100, 1'b1, 1'b0, '0);
      @(negedge clock);
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      #1;
      check_idle(0, "idle_abc");

      // same block under random back-pressure
      load(0, abc256);
      stream(0, 64, 50, 1'b1, 1'b0, '0);

      // random block, then back-to-back second block
      blk_a = rand_block();
      blk_b = rand_block();
      build_model(blk_a, 32, 64);
      load(0, blk_a);
      stream(0, 64, 70, 1'b0, 1'b1, blk_b);
      build_model(blk_b, 32, 64);
      stream(0, 64, 60, 1'b0, 1'b0, '0);
      @(negedge clock);
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      #1;
      check_idle(0, "idle_b2b");

      // synchronous clear at index 20
      blk_a = rand_block();
      build_model(blk_a, 32, 64);
      load(0, blk_a);
      run_to_index(0, 20);
      drive(0, 1'b0, '0, 1'b1, 1'b1);
      #1;
      check("clear_bready", 64'(o_bready(0)), 64'd0);
      check("clear_w20", o_data(0), wexp[20]);
      @(negedge clock);
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      #1;
      check_idle(0, "after_clear");
      check("after_clear_idx", 64'(o_idx(0)), 64'd0);

      // asynchronous reset mid-block
      load(0, blk_a);
      run_to_index(0, 5);
      check("pre_rst_w5", o_data(0), wexp[5]);
      reset = 1'b1;
      #1;
      check_reset_vals(0, "async_rst");
      @(negedge clock);
      reset = 1'b0;

      // SHA-512 abc, full throughput
      build_model(abc512, 64, 80);
      load(1, abc512);
      stream(1, 80, 100, 1'b1, 1'b0, '0);
      @(negedge clock);
      drive(1, 1'b0, '0, 1'b0, 1'b0);
      #1;
      check_idle(1, "idle_512");

      // SHA-512 random block under back-pressure
      blk_a = rand_block();
      build_model(blk_a, 64, 80);
      load(1, blk_a);
      stream(1, 80, 50, 1'b0, 1'b0, '0);
      @(negedge clock);
      drive(1, 1'b0, '0, 1'b0, 1'b0);
      #1;
      check_idle(1, "idle_512r");

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
